// File: rtl/dpram_access_arbiter.sv
// dpram_access_arbiter: shares a true dual-port RAM between requesters A and B.
// After reset it clears the RAM through port A, one word per cycle. It then
// arbitrates same-address collisions so the RAM never sees a write-write or a
// read-during-write on one address. Read data comes back with a strobe, and
// resolved collisions are counted.
//
// Handshake: a requester raises req with we/addr/din and holds all of them
// stable until it sees gnt. The access is accepted on the rising edge where
// req & gnt are both high. gnt is combinational and may drop while req is
// held. A read returns rvalid/dout one cycle after its accepting edge.
module dpram_access_arbiter #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic                  gnt_a,
  output logic                  gnt_b,
  output logic                  rvalid_a,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  init_done,
  output logic [CNT_WIDTH-1:0]  conflict_cnt,
  output logic [0:0]            fsm_state,
  output logic                  mem_we_a,
  output logic [ADDR_WIDTH-1:0] mem_addr_a,
  output logic [DATA_WIDTH-1:0] mem_din_a,
  input  logic [DATA_WIDTH-1:0] mem_dout_a,
  output logic                  mem_we_b,
  output logic [ADDR_WIDTH-1:0] mem_addr_b,
  output logic [DATA_WIDTH-1:0] mem_din_b,
  input  logic [DATA_WIDTH-1:0] mem_dout_b
);

  localparam logic [0:0]            ST_INIT   = 1'b0;
  localparam logic [0:0]            ST_RUN    = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] init_ptr;
  logic                  prio;      // 0: A wins the next collision, 1: B wins
  logic                  run;
  logic                  conflict;

  assign run       = (state == ST_RUN);
  assign init_done = run;
  assign fsm_state = state;

  // A read-read pair to one address is harmless, so it does not count as a collision.
  assign conflict = run & req_a & req_b & (addr_a == addr_b) & (we_a | we_b);
  assign gnt_a    = run & req_a & ~(conflict & prio);
  assign gnt_b    = run & req_b & ~(conflict & ~prio);

  assign dout_a = mem_dout_a;
  assign dout_b = mem_dout_b;

  // Port A carries the clearing sweep during INIT and the granted A access in RUN.
  // The INIT write is held off while reset is asserted.
  always_comb begin
    mem_we_a   = gnt_a & we_a;
    mem_addr_a = addr_a;
    mem_din_a  = din_a;
    if (!run) begin
      mem_we_a   = rst_n;
      mem_addr_a = init_ptr;
      mem_din_a  = INIT_VALUE;
    end
  end

  // Port B is idle during INIT because gnt_b is low there.
  always_comb begin
    mem_we_b   = gnt_b & we_b;
    mem_addr_b = addr_b;
    mem_din_b  = din_b;
  end

  // Init sweep: one word per edge. Switch to RUN after the last address is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_ptr <= '0;
    end else if (state == ST_INIT) begin
      init_ptr <= init_ptr + 1'b1;
      if (init_ptr == LAST_ADDR) begin
        state <= ST_RUN;
      end
    end
  end

  // After a collision, priority passes to the loser, so no port stalls more than one cycle.
  // The counter saturates at its maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio         <= 1'b0;
      conflict_cnt <= '0;
    end else if (conflict) begin
      prio <= ~prio;
      if (conflict_cnt != CNT_MAX) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

  // rvalid lines up with the RAM's one-cycle registered read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
    end else begin
      rvalid_a <= gnt_a & ~we_a;
      rvalid_b <= gnt_b & ~we_b;
    end
  end

endmodule

// File: tb/tb_dpram_access_arbiter.sv
// Bench for dpram_access_arbiter. It provides a behavioural dual-port RAM with
// read-first timing and random power-up contents. A reference model compares the
// DUT on every negedge, and directed scenarios check literal expected values.
module tb_dpram_access_arbiter;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
  localparam logic [DW-1:0] INIT_V = 8'h00;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          req_a, we_a, req_b, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] din_a, din_b;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b, init_done;
  logic [DW-1:0] dout_a, dout_b;
  logic [CW-1:0] conflict_cnt;
  logic [0:0]    fsm_state;
  logic          mem_we_a, mem_we_b;
  logic [AW-1:0] mem_addr_a, mem_addr_b;
  logic [DW-1:0] mem_din_a, mem_din_b, mem_dout_a, mem_dout_b;

  int errors = 0;
  int checks = 0;

  dpram_access_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VALUE(INIT_V), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .dout_a(dout_a), .dout_b(dout_b), .init_done(init_done),
    .conflict_cnt(conflict_cnt), .fsm_state(fsm_state),
    .mem_we_a(mem_we_a), .mem_addr_a(mem_addr_a), .mem_din_a(mem_din_a), .mem_dout_a(mem_dout_a),
    .mem_we_b(mem_we_b), .mem_addr_b(mem_addr_b), .mem_din_b(mem_din_b), .mem_dout_b(mem_dout_b)
  );

  // ---------------- RAM macro model ----------------
  logic [DW-1:0] ram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom_range(1, 255));
  always @(posedge clk) begin
    if (mem_we_a) ram[mem_addr_a] <= mem_din_a;
    if (mem_we_b) ram[mem_addr_b] <= mem_din_b;
    mem_dout_a <= ram[mem_addr_a];
    mem_dout_b <= ram[mem_addr_b];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + compare ----------------
  int            m_edges;            // init writes completed since reset
  logic          m_prio;             // 0 = A has priority
  int            m_cnt;
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_rv_a, m_rv_b;
  logic [DW-1:0] m_rd_a, m_rd_b;

  always @(negedge clk) begin
    logic done, coll, ea, eb;
    if (!rst_n) begin
      chk("m_rst_gnt_a", gnt_a, 0);
      chk("m_rst_gnt_b", gnt_b, 0);
      chk("m_rst_rvalid_a", rvalid_a, 0);
      chk("m_rst_rvalid_b", rvalid_b, 0);
      chk("m_rst_init_done", init_done, 0);
      chk("m_rst_cnt", conflict_cnt, 0);
      chk("m_rst_mem_we_a", mem_we_a, 0);
      chk("m_rst_mem_we_b", mem_we_b, 0);
      m_edges = 0; m_prio = 0; m_cnt = 0; m_rv_a = 0; m_rv_b = 0;
    end else begin
      done = (m_edges == DEPTH);
      coll = done && req_a && req_b && (addr_a == addr_b) && (we_a || we_b);
      ea   = done && req_a && !(coll && m_prio);
      eb   = done && req_b && !(coll && !m_prio);
      chk("m_gnt_a", gnt_a, ea);
      chk("m_gnt_b", gnt_b, eb);
      chk("m_init_done", init_done, done);
      chk("m_cnt", conflict_cnt, m_cnt);
      chk("m_rvalid_a", rvalid_a, m_rv_a);
      chk("m_rvalid_b", rvalid_b, m_rv_b);
      if (m_rv_a) chk("m_dout_a", dout_a, m_rd_a);
      if (m_rv_b) chk("m_dout_b", dout_b, m_rd_b);
      if (!done) begin
        chk("m_init_we_a", mem_we_a, 1);
        chk("m_init_addr_a", mem_addr_a, m_edges);
        chk("m_init_din_a", mem_din_a, INIT_V);
        chk("m_init_we_b", mem_we_b, 0);
        m_mem[m_edges] = INIT_V;
        m_edges++;
        m_rv_a = 0; m_rv_b = 0;
      end else begin
        chk("m_mem_we_a", mem_we_a, ea && we_a);
        chk("m_mem_we_b", mem_we_b, eb && we_b);
        if (ea) chk("m_mem_addr_a", mem_addr_a, addr_a);
        if (eb) chk("m_mem_addr_b", mem_addr_b, addr_b);
        if (ea && we_a) chk("m_mem_din_a", mem_din_a, din_a);
        if (eb && we_b) chk("m_mem_din_b", mem_din_b, din_b);
        m_rv_a = ea && !we_a; m_rd_a = m_mem[addr_a];
        m_rv_b = eb && !we_b; m_rd_b = m_mem[addr_b];
        if (ea && we_a) m_mem[addr_a] = din_a;
        if (eb && we_b) m_mem[addr_b] = din_b;
        if (coll) begin
          m_prio = !m_prio;
          if (m_cnt < CMAX) m_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic set_a(input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    req_a = 1'b1; we_a = w; addr_a = ad; din_a = d;
  endtask

  task automatic set_b(input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    req_b = 1'b1; we_b = w; addr_b = ad; din_b = d;
  endtask

  // Hold requests until granted; drop each one after its accepting edge.
  task automatic serve(input string name, input int max_cycles);
    int   n = 0;
    logic ga, gb;
    while ((req_a || req_b) && n < max_cycles) begin
      @(negedge clk);
      ga = gnt_a; gb = gnt_b;
      @(posedge clk); #1;
      if (ga) req_a = 1'b0;
      if (gb) req_b = 1'b0;
      n++;
    end
    chk({name, "_timeout"}, {30'd0, req_a, req_b}, 0);
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (!init_done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, n, DEPTH);
  endtask

  task automatic read_a(input logic [AW-1:0] ad, input logic [DW-1:0] exp, input string name);
    set_a(1'b0, ad, 8'h00);
    serve(name, 4);
    chk({name, "_rvalid"}, rvalid_a, 1);
    chk({name, "_dout"}, dout_a, exp);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    req_a = 0; we_a = 0; addr_a = '0; din_a = '0;
    req_b = 0; we_b = 0; addr_b = '0; din_b = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_init_done", init_done, 0);
    chk("rst_cnt", conflict_cnt, 0);
    chk("rst_mem_we_a", mem_we_a, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_init("init_len");

    // Every location reads back as the init value, back-to-back on both ports.
    for (int i = 0; i < DEPTH; i++) begin
      set_a(1'b0, AW'(i), 8'h00);
      set_b(1'b0, AW'(DEPTH - 1 - i), 8'h00);
      serve("sweep_rd", 4);
      chk("sweep_rvalid_a", rvalid_a, 1);
      chk("sweep_dout_a", dout_a, 8'h00);
      chk("sweep_dout_b", dout_b, 8'h00);
    end

    // Write followed by read on A.
    set_a(1'b1, 4'd3, 8'hA5);
    serve("wr3", 4);
    read_a(4'd3, 8'hA5, "rd3");
    chk("cnt_after_rd3", conflict_cnt, 0);

    // Write-write collision on addr 5 with A priority.
    set_a(1'b1, 4'd5, 8'hF0);
    set_b(1'b1, 4'd5, 8'h0F);
    @(negedge clk);
    chk("ww_c1_gnt_a", gnt_a, 1);
    chk("ww_c1_gnt_b", gnt_b, 0);
    @(posedge clk); #1 req_a = 1'b0;
    chk("ww_cnt", conflict_cnt, 1);
    @(negedge clk);
    chk("ww_c2_gnt_b", gnt_b, 1);
    @(posedge clk); #1 req_b = 1'b0;
    read_a(4'd5, 8'h0F, "rd5");

    // Read-vs-write collision on addr 7 with B priority.
    set_a(1'b0, 4'd7, 8'h00);
    set_b(1'b1, 4'd7, 8'h5A);
    @(negedge clk);
    chk("rw_c1_gnt_a", gnt_a, 0);
    chk("rw_c1_gnt_b", gnt_b, 1);
    @(posedge clk); #1 req_b = 1'b0;
    chk("rw_cnt", conflict_cnt, 2);
    @(negedge clk);
    chk("rw_c2_gnt_a", gnt_a, 1);
    @(posedge clk); #1 req_a = 1'b0;
    chk("rw_rvalid_a", rvalid_a, 1);
    chk("rw_dout_a", dout_a, 8'h5A);

    // Non-conflicting pairs: same-address read-read, different-address writes.
    set_a(1'b0, 4'd2, 8'h00);
    set_b(1'b0, 4'd2, 8'h00);
    @(negedge clk);
    chk("rr_gnt_a", gnt_a, 1);
    chk("rr_gnt_b", gnt_b, 1);
    @(posedge clk); #1 req_a = 1'b0; req_b = 1'b0;
    chk("rr_dout_b", dout_b, 8'h00);
    set_a(1'b1, 4'd1, 8'h11);
    set_b(1'b1, 4'd9, 8'h99);
    @(negedge clk);
    chk("ww_diff_gnt_a", gnt_a, 1);
    chk("ww_diff_gnt_b", gnt_b, 1);
    @(posedge clk); #1 req_a = 1'b0; req_b = 1'b0;
    chk("nc_cnt", conflict_cnt, 2);
    set_a(1'b0, 4'd1, 8'h00);
    set_b(1'b0, 4'd9, 8'h00);
    serve("rd_1_9", 4);
    chk("rd1_dout_a", dout_a, 8'h11);
    chk("rd9_dout_b", dout_b, 8'h99);

    // Stalled loser wins against a fresh conflicting request from the winner.
    set_a(1'b1, 4'd4, 8'h44);
    set_b(1'b1, 4'd4, 8'h4B);
    @(negedge clk);
    chk("st_c1_gnt_a", gnt_a, 1);
    @(posedge clk); #1 din_a = 8'h4C;
    chk("st_cnt1", conflict_cnt, 3);
    @(negedge clk);
    chk("st_c2_gnt_a", gnt_a, 0);
    chk("st_c2_gnt_b", gnt_b, 1);
    @(posedge clk); #1 req_b = 1'b0;
    chk("st_cnt2", conflict_cnt, 4);
    serve("st_a", 4);
    read_a(4'd4, 8'h4C, "rd4");

    // Reset while a read is granted but before its rvalid.
    set_a(1'b0, 4'd3, 8'h00);
    #2;
    chk("mid_gnt_a", gnt_a, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt_a", gnt_a, 0);
    chk("mid_rst_rvalid_a", rvalid_a, 0);
    chk("mid_rst_init_done", init_done, 0);
    chk("mid_rst_cnt", conflict_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_init("reinit_len");
    serve("post_init_rd", 4);
    chk("reinit_rvalid_a", rvalid_a, 1);
    chk("reinit_dout_a", dout_a, 8'h00);

    // Saturation: drive more collisions than the counter can hold.
    for (int k = 1; k <= 17; k++) begin
      set_a(1'b1, 4'd6, DW'(k));
      set_b(1'b1, 4'd6, DW'(k + 100));
      serve("sat", 4);
      chk("sat_cnt", conflict_cnt, (k < CMAX) ? k : CMAX);
    end
    chk("sat_hold", conflict_cnt, 4'hF);
    read_a(4'd6, 8'h75, "rd6");

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dpram_access_arbiter.md
# dpram_access_arbiter

Single-clock access controller that shares a true dual-port RAM between two requesters (A, B). On reset it clears the RAM with a sequenced initialisation sweep. After that it arbitrates same-address collisions so that no write-write or read-during-write conflict ever reaches the RAM. It sits between the requester logic and the DPRAM macro, driving both RAM ports. It also returns read data with a valid strobe and counts resolved conflicts.

## Interface
- DATA_WIDTH, 8, data width of RAM and requester buses
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH
- INIT_VALUE, 0, word written to every location during init sweep
- CNT_WIDTH, 16, width of conflict counter
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_a / req_b  in  1  access request, held until granted
- we_a / we_b  in  1  1 = write, 0 = read; qualified by req
- addr_a / addr_b  in  ADDR_WIDTH  access address
- din_a / din_b  in  DATA_WIDTH  write data
- gnt_a / gnt_b  out  1  combinational grant; access accepted on edge where req & gnt
- rvalid_a / rvalid_b  out  1  registered; high one cycle, one cycle after a granted read
- dout_a / dout_b  out  DATA_WIDTH  read data, valid when rvalid
- init_done  out  1  high once init sweep has completed
- conflict_cnt  out  CNT_WIDTH  saturating count of cycles with an arbitrated collision
- mem_we_a, mem_addr_a, mem_din_a, mem_dout_a  out/out/out/in  1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH  RAM port A
- mem_we_b, mem_addr_b, mem_din_b, mem_dout_b  out/out/out/in  same widths  RAM port B

The RAM is clocked by clk on both ports. It has one-cycle registered read latency.

## Operation
- FSM states are INIT and RUN. Reset enters INIT.
- INIT behaviour:
  - gnt_a = gnt_b = 0.
  - Port A writes INIT_VALUE to address init_ptr, then increments init_ptr. init_ptr runs 0..DEPTH-1.
  - mem_we_b = 0.
  - After the write to DEPTH-1, go to RUN and set init_done = 1.
- RUN, conflict definition: req_a & req_b & (addr_a == addr_b) & (we_a | we_b).
- RUN, grants:
  - No conflict: gnt_x = req_x for each port.
  - Read-read to the same address is not a conflict; both ports are granted.
  - Conflict: only the port named by prio is granted. The loser sees gnt = 0 and must hold its request.
- Priority pointer prio:
  - Reset value is A.
  - On every conflict cycle, prio flips to the losing port, so the loser wins the next collision. This guarantees a stall of at most one cycle per collision.
  - prio is unchanged on non-conflict cycles.
- RAM drive:
  - mem_we_x = gnt_x & we_x.
  - mem_addr_x = addr_x in RUN.
  - mem_din_x = din_x.
  - The RAM is never written except when granted.
- Reads: rvalid_x <= gnt_x & ~we_x, and dout_x = mem_dout_x. A write from the opposite port in the same cycle can never hit the read address.
- conflict_cnt increments by 1 on each conflict cycle and saturates at all-ones.
- Requests in INIT are ignored; no grant and no rvalid are produced.

## Timing
- Reset values: gnt_a = gnt_b = 0; rvalid_a = rvalid_b = 0; init_done = 0; conflict_cnt = 0; prio = A; init_ptr = 0; state = INIT; all mem_we = 0.
- INIT takes exactly DEPTH cycles:
  - The first rising edge after rst_n deasserts writes address 0.
  - init_done rises after edge DEPTH. With DEPTH = 16, that is after the 16th edge.
- Grant latency is zero: combinational in the same cycle as req in RUN.
- Read latency: rvalid and dout are valid in the cycle after the granting edge.
- Back-to-back granted reads yield rvalid high on consecutive cycles.
- A stalled loser is granted on the next cycle if it still requests, including against a new conflicting request from the winner.
- Reset mid-operation:
  - Outputs return to reset values immediately (asynchronously).
  - Any in-flight rvalid is dropped.
  - INIT re-runs from address 0 after deassertion.

## Test plan
- Reset with DEPTH = 16 and INIT_VALUE = 8'h00. Expect init_done low for 16 edges then high; read of every address returns 8'h00.
- A writes 8'hA5 to addr 3, then reads addr 3. Expect gnt_a the same cycle; rvalid_a one cycle after the read grant with dout_a = 8'hA5; conflict_cnt stays 0.
- A writes 8'hF0 and B writes 8'h0F to addr 5 in the same cycle, with prio = A:
  - Cycle 1: gnt_a = 1 and gnt_b = 0; conflict_cnt = 1; prio becomes B.
  - Cycle 2: gnt_b = 1.
  - A later read of addr 5 returns 8'h0F.
- A reads addr 7 while B writes 8'h5A to addr 7, with prio = B. Expect B granted first; A granted next cycle with rvalid_a following and dout_a = 8'h5A; conflict_cnt +1.
- A and B read addr 2 together, plus A writes addr 1 while B writes addr 9 in another cycle. Expect both grants every cycle and conflict_cnt unchanged.
- Assert rst_n low mid-read (after grant, before rvalid). Expect rvalid, gnt and init_done low immediately, conflict_cnt = 0, and a full 16-cycle INIT sweep again. Force the counter to all-ones and collide: it holds all-ones.
